ref_phase_gen: RTL and testbench
================================

Name: ref_phase_gen

Overview:
Stimulus generator for the ADPLL phase-detector bench. It runs on the fast FPGA clock and produces a reference clock plus a copy delayed by a programmable number of fast-clock ticks, so the detector can be driven with known phase offsets. Phase updates use a load/ack handshake and take effect only at a reference-period boundary. It is the source side of the ref_clk/gen_clk pair the phase detector consumes.

Parameters:
HALF_PERIOD, 26, fast-clock ticks per half reference period; period P = 2*HALF_PERIOD (52 gives about 4.96 MHz from 258 MHz).
CNT_W, 8, width of the period counter and phase values; must satisfy 2^CNT_W >= P.

Ports:
fpga_clk_i  in  1  fast clock (258 MHz); one clock for the whole block.
reset_i  in  1  asynchronous, active-high reset.
enable_i  in  1  run/stop control for the waveform generator.
phase_i  in  CNT_W  requested delay of shifted_clk_o relative to ref_clk_o, in ticks.
phase_load_i  in  1  single-cycle strobe that captures phase_i.
phase_ack_o  out  1  one-cycle pulse when a pending phase is applied.
phase_err_o  out  1  one-cycle pulse when a load request is rejected.
phase_o  out  CNT_W  currently applied phase.
ref_clk_o  out  1  reference clock, 50% duty.
shifted_clk_o  out  1  reference clock delayed by phase_o ticks.
period_start_o  out  1  one-cycle strobe coincident with each ref_clk_o rising edge.

Behaviour:
- Reset state. Asynchronous reset clears the following:
  - cnt = 0, pending_valid = 0, pending_phase = 0, phase_o = 0.
  - All outputs are 0.
- Period counter:
  - cnt counts 0..P-1 and wraps to 0 while enable_i = 1.
  - While enable_i = 0, cnt is forced to 0.
- Registered outputs (1-cycle latency from cnt). Let s = (cnt - phase_o) mod P, computed in CNT_W+1 bits with conditional add of P.
  - ref_clk_o <= enable_i & (cnt < HALF_PERIOD).
  - shifted_clk_o <= enable_i & (s < HALF_PERIOD).
  - period_start_o <= enable_i & (cnt == 0).
- Resulting waveform: shifted_clk_o rises exactly phase_o ticks after ref_clk_o rises. Phase 0 makes the two outputs identical.
- Load handshake:
  - Valid load: when phase_load_i = 1 and phase_i < P, pending_phase <= phase_i and pending_valid <= 1.
  - Rejected load: when phase_load_i = 1 and phase_i >= P, phase_err_o pulses on the next cycle and pending state is unchanged.
  - Multiple loads before the apply point: last valid load wins; only one ack is issued.
- Apply point:
  - Occurs on the cycle where enable_i = 1, cnt == P-1 and pending_valid = 1.
  - On that cycle: phase_o <= pending_phase, pending_valid <= 0, and phase_ack_o pulses on the next cycle.
  - The new phase therefore governs the period that starts at cnt = 0.
- Simultaneous load and apply: the apply uses the old pending_phase. The new load is captured and pending_valid stays 1, so it is applied at the following boundary with a second ack.
- Phase-change transient: during the first period after a phase change, shifted_clk_o may have one lengthened or shortened high/low phase. It must never toggle more than once per tick, and must settle to the new offset within one period.
- enable_i deasserted:
  - ref_clk_o, shifted_clk_o and period_start_o go low on the next edge.
  - phase_o, pending_phase and pending_valid are retained; no apply occurs while disabled.
  - On re-enable, cnt starts at 0, so the first ref_clk_o high begins one cycle later.
- Reset mid-operation: all state clears immediately (asynchronously), including any pending load. No ack is emitted after reset release.
- Handshake output rules: phase_ack_o and phase_err_o are never high for more than one cycle per event.

Test Plan:
1. Reset, then enable_i = 1 with HALF_PERIOD = 26 -> ref_clk_o is 26 ticks high then 26 low, period_start_o every 52 ticks, shifted_clk_o identical to ref_clk_o, phase_o = 0.
2. Load phase_i = 13 at cnt = 10 -> phase_ack_o pulses one cycle after cnt = 51, phase_o = 13, and shifted_clk_o rises 13 ticks after each subsequent ref_clk_o rise.
3. Load phase_i = 52, then phase_i = 255 -> phase_err_o pulses once per load, no phase_ack_o, phase_o unchanged.
4. Load 5 at cnt = 3 and 20 at cnt = 30 in the same period -> exactly one ack, phase_o = 20. Separately, a load of 40 at cnt = 51 while 20 is pending -> 20 is applied, then 40 is applied one period later with a second ack.
5. Load phase_i = 51 -> shifted_clk_o rises one tick before each ref_clk_o rise and duty stays 26/26. Separately, a sweep of phase 0..51 yields the delay equal to phase_o for every value.
6. Drop enable_i mid-period -> all clock outputs are low next cycle and restart cleanly from cnt = 0 on re-enable. Separately, assert reset_i with a pending load -> phase_o = 0 and no ack follows.

Source files
------------

// File: rtl/ref_phase_gen.sv
// Reference/shifted clock pair generator for the ADPLL phase-detector bench.
// The shifted copy trails ref_clk_o by phase_o fast-clock ticks; phase updates land on period boundaries.
module ref_phase_gen #(
  parameter int HALF_PERIOD = 26,
  parameter int CNT_W       = 8
) (
  input  logic             fpga_clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] phase_i,
  input  logic             phase_load_i,
  output logic             phase_ack_o,
  output logic             phase_err_o,
  output logic [CNT_W-1:0] phase_o,
  output logic             ref_clk_o,
  output logic             shifted_clk_o,
  output logic             period_start_o
);

  localparam logic [CNT_W:0]   P_W    = (CNT_W+1)'(2*HALF_PERIOD);
  localparam logic [CNT_W-1:0] PM1_C  = CNT_W'(2*HALF_PERIOD-1);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF_PERIOD);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] r_pend_phase;
  logic             r_pend_valid;
  logic             r_ack;
  logic             r_err;
  logic             r_ref;
  logic             r_shift;
  logic             r_pstart;

  logic             w_last;
  logic             w_in_range;
  logic             w_load_ok;
  logic             w_apply;
  logic [CNT_W:0]   w_diff;
  logic [CNT_W:0]   w_s;

  assign w_last     = (r_cnt == PM1_C);
  assign w_in_range = ({1'b0, phase_i} < P_W);
  assign w_load_ok  = phase_load_i & w_in_range;
  assign w_apply    = enable_i & w_last & r_pend_valid;

  // Position within the shifted period; the borrow bit selects the wrap-around correction.
  assign w_diff = {1'b0, r_cnt} - {1'b0, r_phase};
  assign w_s    = w_diff[CNT_W] ? (w_diff + P_W) : w_diff;

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else if (!enable_i || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A load landing on the apply cycle is kept pending: the apply consumes the old value.
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_phase      <= '0;
      r_pend_phase <= '0;
      r_pend_valid <= 1'b0;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_ack <= w_apply;
      r_err <= phase_load_i & ~w_in_range;
      if (w_apply) begin
        r_phase <= r_pend_phase;
      end
      if (w_load_ok) begin
        r_pend_phase <= phase_i;
        r_pend_valid <= 1'b1;
      end else if (w_apply) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ref    <= 1'b0;
      r_shift  <= 1'b0;
      r_pstart <= 1'b0;
    end else begin
      r_ref    <= enable_i & (r_cnt < HALF_C);
      r_shift  <= enable_i & (w_s < {1'b0, HALF_C});
      r_pstart <= enable_i & (r_cnt == '0);
    end
  end

  assign phase_ack_o    = r_ack;
  assign phase_err_o    = r_err;
  assign phase_o        = r_phase;
  assign ref_clk_o      = r_ref;
  assign shifted_clk_o  = r_shift;
  assign period_start_o = r_pstart;

endmodule

// File: tb/tb_ref_phase_gen.sv
// Directed bench for ref_phase_gen: waveform shape, load/ack/err handshake, enable and reset behaviour.
module tb_ref_phase_gen;
  localparam int HP = 26;
  localparam int P  = 52;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] ph_i;
  logic         ld;
  logic         ack, err, ref_o, sh_o, ps_o;
  logic [W-1:0] ph_o;

  int tests = 0, fails = 0;
  int mcnt = 0, ack_cnt = 0, a0, d, hi, pst, mism;
  bit got;

  ref_phase_gen #(.HALF_PERIOD(HP), .CNT_W(W)) dut (
    .fpga_clk_i(clk), .reset_i(rst), .enable_i(en), .phase_i(ph_i),
    .phase_load_i(ld), .phase_ack_o(ack), .phase_err_o(err), .phase_o(ph_o),
    .ref_clk_o(ref_o), .shifted_clk_o(sh_o), .period_start_o(ps_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mcnt tracks the DUT's internal counter after each edge.
  task automatic tick;
    @(posedge clk);
    #1;
    if (rst || !en) mcnt = 0;
    else mcnt = (mcnt == P-1) ? 0 : mcnt + 1;
    if (ack) ack_cnt++;
  endtask

  task automatic wait_cnt(input int c);
    int n = 0;
    while (mcnt != c && n < 200) begin tick; n++; end
    if (mcnt != c) begin
      fails++;
      $error("FAIL wait_cnt: got %0d expected %0d", mcnt, c);
    end
  endtask

  task automatic load(input int v);
    ph_i = W'(v);
    ld = 1'b1;
    tick;
    ld = 1'b0;
  endtask

  task automatic wait_ack(output bit g);
    int n = 0;
    while (!ack && n < 120) begin tick; n++; end
    g = ack;
  endtask

  // Skips one ref rise (phase-change transient), then counts ticks from the next ref rise to the shifted rise.
  task automatic measure_delay(output int dd);
    int n = 0, rises = 0;
    logic pr, ps;
    dd = -1;
    pr = ref_o;
    ps = sh_o;
    while (rises < 2 && n < 300) begin
      ps = sh_o;
      tick; n++;
      if (ref_o && !pr) rises++;
      pr = ref_o;
    end
    if (sh_o && !ps) dd = 0;
    else begin
      for (int k = 1; k < P + 2; k++) begin
        ps = sh_o;
        tick;
        if (sh_o && !ps) begin dd = k; break; end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ld = 1'b0; ph_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ref", ref_o, 0);
    chk("rst_sh", sh_o, 0);
    chk("rst_ps", ps_o, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_phase", ph_o, 0);
    rst = 1'b0;
    mcnt = 0;

    // 1: basic waveform, phase 0
    en = 1'b1;
    tick;
    chk("t1_first_ref", ref_o, 1);
    chk("t1_first_ps", ps_o, 1);
    hi = 0; pst = 0; mism = 0;
    repeat (P) begin
      tick;
      if (ref_o) hi++;
      if (ps_o) pst++;
      if (sh_o !== ref_o) mism++;
    end
    chk("t1_ref_high", hi, HP);
    chk("t1_pstart", pst, 1);
    chk("t1_sh_eq_ref", mism, 0);
    chk("t1_phase", ph_o, 0);

    // 2: phase 13 loaded at cnt 10
    wait_cnt(10);
    load(13);
    wait_cnt(51);
    chk("t2_ack_early", ack, 0);
    tick;
    chk("t2_ack", ack, 1);
    chk("t2_phase", ph_o, 13);
    tick;
    chk("t2_ack_once", ack, 0);
    measure_delay(d);
    chk("t2_delay", d, 13);

    // 3: out-of-range loads
    load(52);
    chk("t3_err52", err, 1);
    chk("t3_noack52", ack, 0);
    tick;
    chk("t3_err52_once", err, 0);
    load(255);
    chk("t3_err255", err, 1);
    tick;
    chk("t3_err255_once", err, 0);
    a0 = ack_cnt;
    repeat (60) tick;
    chk("t3_no_ack", ack_cnt - a0, 0);
    chk("t3_phase", ph_o, 13);

    // 4a: two loads in one period, last wins, one ack
    wait_cnt(3);
    load(5);
    wait_cnt(30);
    a0 = ack_cnt;
    load(20);
    repeat (60) tick;
    chk("t4_one_ack", ack_cnt - a0, 1);
    chk("t4_phase", ph_o, 20);

    // 4b: load on the apply cycle is deferred one period
    wait_cnt(10);
    load(20);
    wait_cnt(51);
    a0 = ack_cnt;
    load(40);
    chk("t4b_ack1", ack, 1);
    chk("t4b_phase1", ph_o, 20);
    repeat (P) tick;
    chk("t4b_ack2", ack, 1);
    chk("t4b_phase2", ph_o, 40);
    repeat (P) tick;
    chk("t4b_acks", ack_cnt - a0, 2);

    // 5: phase 51, then full sweep
    load(51);
    wait_ack(got);
    chk("t5_ack51", got, 1);
    measure_delay(d);
    chk("t5_delay51", d, 51);
    hi = 0;
    repeat (P) begin tick; if (sh_o) hi++; end
    chk("t5_duty51", hi, HP);
    for (int v = 0; v < P; v++) begin
      load(v);
      wait_ack(got);
      chk("t5_sweep_ack", got, 1);
      measure_delay(d);
      chk($sformatf("t5_sweep_delay_%0d", v), d, v);
    end

    // 6a: disable mid-period with a pending load
    wait_cnt(15);
    load(9);
    wait_cnt(20);
    chk("t6_ref_before", ref_o, 1);
    chk("t6_sh_before", sh_o, 1);
    en = 1'b0;
    a0 = ack_cnt;
    tick;
    chk("t6_ref_off", ref_o, 0);
    chk("t6_sh_off", sh_o, 0);
    chk("t6_ps_off", ps_o, 0);
    repeat (60) tick;
    chk("t6_no_apply", ack_cnt - a0, 0);
    chk("t6_phase_kept", ph_o, 51);
    en = 1'b1;
    tick;
    chk("t6_restart_ref", ref_o, 1);
    chk("t6_restart_ps", ps_o, 1);
    wait_ack(got);
    chk("t6_pend_ack", got, 1);
    chk("t6_pend_phase", ph_o, 9);

    // 6b: reset with a pending load
    wait_cnt(10);
    load(30);
    rst = 1'b1;
    #1;
    chk("t6r_phase", ph_o, 0);
    chk("t6r_ref", ref_o, 0);
    chk("t6r_sh", sh_o, 0);
    chk("t6r_ack", ack, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mcnt = 0;
    a0 = ack_cnt;
    repeat (120) tick;
    chk("t6r_no_ack", ack_cnt - a0, 0);
    chk("t6r_phase_after", ph_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
